irq_fetch_ctrl: RTL and testbench
=================================

Name: irq_fetch_ctrl

Overview:
- Interrupt controller and PC-redirect sequencer for the fetch stage.
- Latches edge-triggered interrupt requests, applies a mask, and picks one winner by fixed priority.
- Drives the fetch stage's interrupt_en / interrupt_handling_addr pair to vector into a handler, saves the return PC, and redirects back to it on mret.
- Sits beside fetch; consumes the same stall and branch-redirect signals fetch uses.

Parameters:
NUM_IRQ, 4, number of interrupt sources (1..16)
VEC_BASE, 32'h0000_0100, word address of vector 0
VEC_STRIDE, 4, word distance between consecutive vectors

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
irq_in  in  NUM_IRQ  level request lines; rising edge sets pending
global_en  in  1  global interrupt enable
irq_mask_wr  in  1  load mask register this cycle
irq_mask_wdata  in  NUM_IRQ  new mask (1 = enabled)
stall  in  1  fetch stall; PC does not load while high
pc  in  32  current fetch PC
redirect_valid  in  1  branch/jump redirect into fetch this cycle (fetch's pc_next_sel)
redirect_addr  in  32  redirect target (branch or jalr address)
mret_EXE  in  1  return-from-interrupt instruction in EXE
interrupt_en  out  1  fetch override select
interrupt_handling_addr  out  32  vector or return address
flush_IF  out  1  discard instruction currently in IF
irq_ack  out  NUM_IRQ  one-hot, 1-cycle pulse on dispatch
irq_id  out  4  id of the interrupt in service
in_service  out  1  handler active
epc  out  32  saved return PC

Behaviour:
- Reset (async, rst_n low): state=IDLE, pending=0, mask=all ones, irq_in_q=0, epc=0, irq_id=0. All outputs 0 except epc=0.
- Edge detect: pending[i] sets when irq_in[i] & ~irq_in_q[i]. It clears on dispatch of i. A simultaneous set and clear of the same bit leaves it set.
- Mask write takes effect the next cycle and does not clear pending.
- Eligible = pending & mask & {NUM_IRQ{global_en}}. Winner = lowest eligible index.
- IDLE:
  - Outputs low.
  - If eligible != 0: latch winner into irq_id, go to DISPATCH.
- DISPATCH:
  - interrupt_en=1; interrupt_handling_addr = VEC_BASE + irq_id*VEC_STRIDE (32-bit, wraps modulo 2^32).
  - Winner is frozen; a higher-priority arrival does not preempt it.
  - If stall=1: hold.
  - If stall=0 (transfer cycle):
    - epc <= redirect_valid ? redirect_addr : pc.
    - Clear pending[irq_id]; irq_ack[irq_id]=1; flush_IF=1.
    - Go to IN_SERVICE.
- IN_SERVICE:
  - in_service=1; no new dispatch (no nesting).
  - Pending bits keep accumulating.
  - mret_EXE=1: go to RETURN.
- RETURN:
  - interrupt_en=1; interrupt_handling_addr=epc.
  - If stall=0: flush_IF=1; go to IDLE.
  - Any request eligible then can dispatch starting the following cycle: a one-cycle IDLE is mandatory.
- Error and boundary cases:
  - mret_EXE outside IN_SERVICE is ignored.
  - global_en dropping during DISPATCH does not cancel the dispatch.
  - irq_in held high produces one pending event only.
  - Reset mid-DISPATCH or mid-RETURN aborts immediately, with no ack.
- Latency: a rising edge at cycle N gives pending at N+1, DISPATCH at N+2, and the earliest transfer at N+2.

Optional Feature:
- Macro: IRQ_STATS_EN.
- Defined: adds outputs irq_count[15:0] and dispatch_stall_cycles[15:0].
  - irq_count increments on each transfer.
  - dispatch_stall_cycles increments each DISPATCH cycle with stall=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset, no requests, pc=0x20 -> interrupt_en=0, irq_ack=0, mask=4'hF, in_service=0 for 10 cycles.
- irq_in[2] rises, stall=0, pc=0x40 -> interrupt_en=1 with addr 0x108 two cycles later; in the transfer cycle irq_ack=4'b0100 and flush_IF=1; epc=0x40, in_service=1; then mret_EXE -> addr 0x40 for one cycle, then IDLE.
- irq_in[3] and irq_in[1] rise together -> irq 1 served first (addr 0x104). After the mret transfer, one IDLE cycle, then irq 3 dispatches (addr 0x10C).
- DISPATCH with stall=1 for 3 cycles, then stall=0 with redirect_valid=1 and redirect_addr=0x88 -> interrupt_en held all 4 cycles, a single irq_ack pulse, epc=0x88.
- Mask write 4'b1110, then irq_in[0] rises -> no dispatch. Mask write 4'hF -> irq 0 dispatches (addr 0x100) without a new edge.
- Reset asserted during DISPATCH -> interrupt_en=0 asynchronously, pending=0, no irq_ack; with IRQ_STATS_EN, irq_count=0.

Source files
------------

// File: rtl/irq_fetch_ctrl_if.sv
// Fetch-side interrupt bundle: request lines, fetch handshake and redirect.
// The controller binds the slave modport, the fetch/testbench side the master.
interface irq_fetch_ctrl_if #(
    parameter int unsigned NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               global_en;
    logic               irq_mask_wr;
    logic [NUM_IRQ-1:0] irq_mask_wdata;
    logic               stall;
    logic [31:0]        pc;
    logic               redirect_valid;
    logic [31:0]        redirect_addr;
    logic               mret_EXE;
    logic               interrupt_en;
    logic [31:0]        interrupt_handling_addr;
    logic               flush_IF;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [3:0]         irq_id;
    logic               in_service;
    logic [31:0]        epc;

    modport master (
        output irq_in,
        output global_en,
        output irq_mask_wr,
        output irq_mask_wdata,
        output stall,
        output pc,
        output redirect_valid,
        output redirect_addr,
        output mret_EXE,
        input  interrupt_en,
        input  interrupt_handling_addr,
        input  flush_IF,
        input  irq_ack,
        input  irq_id,
        input  in_service,
        input  epc
    );

    modport slave (
        input  irq_in,
        input  global_en,
        input  irq_mask_wr,
        input  irq_mask_wdata,
        input  stall,
        input  pc,
        input  redirect_valid,
        input  redirect_addr,
        input  mret_EXE,
        output interrupt_en,
        output interrupt_handling_addr,
        output flush_IF,
        output irq_ack,
        output irq_id,
        output in_service,
        output epc
    );
endinterface

// File: rtl/irq_fetch_ctrl.sv
// Interrupt controller and PC-redirect sequencer sitting beside fetch.
// Optional IRQ_STATS_EN adds irq_count / dispatch_stall_cycles counters.
module irq_fetch_ctrl #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    irq_fetch_ctrl_if.slave   bus
`ifdef IRQ_STATS_EN
    ,
    output logic [15:0]       irq_count,
    output logic [15:0]       dispatch_stall_cycles
`endif
);

    localparam logic [31:0] STRIDE_W = 32'(VEC_STRIDE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_SERVICE,
        S_RETURN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [31:0]        r_epc;
    logic [3:0]         r_irq_id;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_ack;
    logic               w_any;
    logic [3:0]         w_win;
    logic               w_latch;
    logic               w_xfer;
    logic [31:0]        w_vec;

    assign w_rise = bus.irq_in & ~r_irq_q;
    assign w_elig = r_pending & r_mask & {NUM_IRQ{bus.global_en}};
    assign w_any  = |w_elig;
    assign w_vec  = VEC_BASE + (32'(r_irq_id) * STRIDE_W);

    assign bus.irq_id = r_irq_id;
    assign bus.epc    = r_epc;
    assign bus.irq_ack = w_ack;

    // Fixed priority: lowest eligible index wins
    always_comb begin
        w_win = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = 4'(i);
            end
        end
    end

    // One-hot acknowledge of the frozen winner in the transfer cycle
    always_comb begin
        w_ack = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_ack[i] = w_xfer && (r_irq_id == 4'(i));
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and fetch override outputs
    always_comb begin
        w_state_nxt                 = r_state;
        w_latch                     = 1'b0;
        w_xfer                      = 1'b0;
        bus.interrupt_en            = 1'b0;
        bus.interrupt_handling_addr = 32'h0;
        bus.flush_IF                = 1'b0;
        bus.in_service              = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                bus.interrupt_en            = 1'b1;
                bus.interrupt_handling_addr = w_vec;
                if (!bus.stall) begin
                    w_xfer       = 1'b1;
                    bus.flush_IF = 1'b1;
                    w_state_nxt  = S_SERVICE;
                end
            end
            S_SERVICE: begin
                bus.in_service = 1'b1;
                if (bus.mret_EXE) begin
                    w_state_nxt = S_RETURN;
                end
            end
            S_RETURN: begin
                bus.interrupt_en            = 1'b1;
                bus.interrupt_handling_addr = r_epc;
                if (!bus.stall) begin
                    bus.flush_IF = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Edge detect history of the request lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_q <= '0;
        end else begin
            r_irq_q <= bus.irq_in;
        end
    end

    // Pending latch: a new edge wins over a same-cycle dispatch clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_ack) | w_rise;
        end
    end

    // Mask register, all sources enabled out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '1;
        end else if (bus.irq_mask_wr) begin
            r_mask <= bus.irq_mask_wdata;
        end
    end

    // Winner is frozen on leaving IDLE so later arrivals cannot preempt it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_id <= 4'd0;
        end else if (w_latch) begin
            r_irq_id <= w_win;
        end
    end

    // Return PC: a taken redirect in the transfer cycle is the true next PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc <= 32'h0;
        end else if (w_xfer) begin
            r_epc <= bus.redirect_valid ? bus.redirect_addr : bus.pc;
        end
    end

`ifdef IRQ_STATS_EN
    // Saturating count of completed dispatches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_count <= 16'h0;
        end else if (w_xfer && (irq_count != 16'hFFFF)) begin
            irq_count <= irq_count + 16'd1;
        end
    end

    // Saturating count of cycles a dispatch waited on a fetch stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispatch_stall_cycles <= 16'h0;
        end else if ((r_state == S_DISPATCH) && bus.stall &&
                     (dispatch_stall_cycles != 16'hFFFF)) begin
            dispatch_stall_cycles <= dispatch_stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_irq_fetch_ctrl.sv
// Directed bench for irq_fetch_ctrl with hand-computed expectations.
// Inputs change 2 time units after the rising edge, checks 1 unit later.
module tb_irq_fetch_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    irq_fetch_ctrl_if #(.NUM_IRQ(4)) bus ();

`ifdef IRQ_STATS_EN
    logic [15:0] irq_count;
    logic [15:0] dispatch_stall_cycles;
`endif

    irq_fetch_ctrl #(
        .NUM_IRQ    (4),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IRQ_STATS_EN
        ,
        .irq_count             (irq_count),
        .dispatch_stall_cycles (dispatch_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        bus.irq_in         = 4'b0000;
        bus.global_en      = 1'b1;
        bus.irq_mask_wr    = 1'b0;
        bus.irq_mask_wdata = 4'h0;
        bus.stall          = 1'b0;
        bus.pc             = 32'h20;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'h0;
        bus.mret_EXE       = 1'b0;
        #1;
        chk("rst_en", 32'(bus.interrupt_en), 32'h0);
        chk("rst_addr", bus.interrupt_handling_addr, 32'h0);
        chk("rst_flush", 32'(bus.flush_IF), 32'h0);
        chk("rst_epc", bus.epc, 32'h0);
        chk("rst_id", 32'(bus.irq_id), 32'h0);
`ifdef IRQ_STATS_EN
        chk("rst_cnt", 32'(irq_count), 32'h0);
`endif
        cyc();
        cyc();
        rst_n = 1'b1;

        // idle with no requests; a stray mret must be ignored
        for (int k = 0; k < 10; k++) begin
            cyc();
            bus.mret_EXE = (k == 3);
            #1;
            chk("idle_en", 32'(bus.interrupt_en), 32'h0);
            chk("idle_ack", 32'(bus.irq_ack), 32'h0);
            chk("idle_svc", 32'(bus.in_service), 32'h0);
        end
        bus.mret_EXE = 1'b0;

        // single request on line 2
        cyc(); bus.irq_in = 4'b0100; bus.pc = 32'h40; #1;
        chk("t2_pre_en", 32'(bus.interrupt_en), 32'h0);
        cyc(); #1;
        chk("t2_pend_en", 32'(bus.interrupt_en), 32'h0);
        cyc(); #1;
        chk("t2_disp_en", 32'(bus.interrupt_en), 32'h1);
        chk("t2_disp_addr", bus.interrupt_handling_addr, 32'h108);
        chk("t2_ack", 32'(bus.irq_ack), 32'h4);
        chk("t2_flush", 32'(bus.flush_IF), 32'h1);
        cyc(); bus.irq_in = 4'b0000; bus.mret_EXE = 1'b1; #1;
        chk("t2_svc", 32'(bus.in_service), 32'h1);
        chk("t2_epc", bus.epc, 32'h40);
        chk("t2_id", 32'(bus.irq_id), 32'h2);
        chk("t2_svc_en", 32'(bus.interrupt_en), 32'h0);
        cyc(); bus.mret_EXE = 1'b0; #1;
        chk("t2_ret_en", 32'(bus.interrupt_en), 32'h1);
        chk("t2_ret_addr", bus.interrupt_handling_addr, 32'h40);
        chk("t2_ret_flush", 32'(bus.flush_IF), 32'h1);
        chk("t2_ret_ack", 32'(bus.irq_ack), 32'h0);
        cyc(); #1;
        chk("t2_idle_en", 32'(bus.interrupt_en), 32'h0);
        chk("t2_idle_svc", 32'(bus.in_service), 32'h0);

        // lines 3 and 1 together, held high throughout
        cyc(); bus.irq_in = 4'b1010; #1;
        cyc(); #1;
        cyc(); #1;
        chk("t3_a_addr", bus.interrupt_handling_addr, 32'h104);
        chk("t3_a_ack", 32'(bus.irq_ack), 32'h2);
        chk("t3_a_id", 32'(bus.irq_id), 32'h1);
        cyc(); bus.mret_EXE = 1'b1; #1;
        chk("t3_a_svc", 32'(bus.in_service), 32'h1);
        cyc(); bus.mret_EXE = 1'b0; #1;
        chk("t3_a_ret", bus.interrupt_handling_addr, 32'h40);
        cyc(); #1;
        chk("t3_gap_en", 32'(bus.interrupt_en), 32'h0);
        cyc(); #1;
        chk("t3_b_addr", bus.interrupt_handling_addr, 32'h10C);
        chk("t3_b_ack", 32'(bus.irq_ack), 32'h8);
        cyc(); bus.mret_EXE = 1'b1; #1;
        cyc(); bus.mret_EXE = 1'b0; #1;
        chk("t3_b_ret_en", 32'(bus.interrupt_en), 32'h1);
        cyc(); #1;
        chk("t3_held_en0", 32'(bus.interrupt_en), 32'h0);
        cyc(); #1;
        chk("t3_held_en1", 32'(bus.interrupt_en), 32'h0);
        cyc(); bus.irq_in = 4'b0000; #1;

        // stalled dispatch, global_en drop, redirect into epc
        cyc(); bus.stall = 1'b1; bus.irq_in = 4'b0001; #1;
        cyc(); #1;
        cyc(); #1;
        chk("t4_s1_en", 32'(bus.interrupt_en), 32'h1);
        chk("t4_s1_addr", bus.interrupt_handling_addr, 32'h100);
        chk("t4_s1_ack", 32'(bus.irq_ack), 32'h0);
        chk("t4_s1_flush", 32'(bus.flush_IF), 32'h0);
        cyc(); bus.global_en = 1'b0; #1;
        chk("t4_s2_en", 32'(bus.interrupt_en), 32'h1);
        chk("t4_s2_ack", 32'(bus.irq_ack), 32'h0);
        cyc(); #1;
        chk("t4_s3_en", 32'(bus.interrupt_en), 32'h1);
        chk("t4_s3_ack", 32'(bus.irq_ack), 32'h0);
        cyc();
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 32'h88;
        #1;
        chk("t4_x_en", 32'(bus.interrupt_en), 32'h1);
        chk("t4_x_ack", 32'(bus.irq_ack), 32'h1);
        cyc();
        bus.redirect_valid = 1'b0;
        bus.global_en = 1'b1;
        bus.mret_EXE = 1'b1;
        #1;
        chk("t4_epc", bus.epc, 32'h88);
        chk("t4_svc_ack", 32'(bus.irq_ack), 32'h0);
        cyc(); bus.mret_EXE = 1'b0; #1;
        chk("t4_ret_addr", bus.interrupt_handling_addr, 32'h88);
        cyc(); bus.irq_in = 4'b0000; #1;

        // masked request dispatches once the mask is reopened
        cyc(); bus.irq_mask_wr = 1'b1; bus.irq_mask_wdata = 4'b1110; #1;
        cyc(); bus.irq_mask_wr = 1'b0; bus.irq_in = 4'b0001; #1;
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("t5_masked_en", 32'(bus.interrupt_en), 32'h0);
        end
        cyc(); bus.irq_mask_wr = 1'b1; bus.irq_mask_wdata = 4'hF; #1;
        cyc(); bus.irq_mask_wr = 1'b0; #1;
        chk("t5_open_en", 32'(bus.interrupt_en), 32'h0);
        cyc(); #1;
        chk("t5_disp_en", 32'(bus.interrupt_en), 32'h1);
        chk("t5_disp_addr", bus.interrupt_handling_addr, 32'h100);
        chk("t5_disp_ack", 32'(bus.irq_ack), 32'h1);
        cyc(); bus.mret_EXE = 1'b1; #1;
        cyc(); bus.mret_EXE = 1'b0; #1;
        cyc(); #1;

        // reset in the middle of a stalled dispatch
        cyc(); bus.stall = 1'b1; bus.irq_in = 4'b0011; #1;
        cyc(); #1;
        cyc(); #1;
        chk("t6_disp_en", 32'(bus.interrupt_en), 32'h1);
        chk("t6_disp_id", 32'(bus.irq_id), 32'h1);
        #2;
        rst_n = 1'b0;
        bus.irq_in = 4'b0000;
        #1;
        chk("t6_rst_en", 32'(bus.interrupt_en), 32'h0);
        chk("t6_rst_ack", 32'(bus.irq_ack), 32'h0);
        chk("t6_rst_id", 32'(bus.irq_id), 32'h0);
`ifdef IRQ_STATS_EN
        chk("t6_rst_cnt", 32'(irq_count), 32'h0);
`endif
        cyc(); bus.stall = 1'b0; rst_n = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("t6_post_en", 32'(bus.interrupt_en), 32'h0);
            chk("t6_post_ack", 32'(bus.irq_ack), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
